muldiv_unit: RTL

Iterative RV64M multiply/divide unit for the EX stage of the pipelined RISC-V core. It executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU over multiple cycles behind a start/busy/done handshake, and the hazard logic stalls IF/ID/EX while it is busy. Operand width is parametrised, so the same block serves RV32M and RV64M builds. Divide-by-zero and signed overflow take a fast path, and an in-flight operation can be aborted by a flush (taken branch).

---
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV M-extension multiply/divide unit with start/busy/done handshake
module muldiv_unit #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [DATA_W-1:0] L_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_hi, r_lo, r_b, r_result;
  logic [2:0]          r_op;
  logic                r_neg;

  logic                w_accept, w_last;
  logic                w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg_res;
  logic [DATA_W-1:0]   w_a_mag, w_b_mag;
  logic                w_div0, w_ovf, w_fast;
  logic [DATA_W-1:0]   w_fast_res, w_field, w_fix_res;
  logic [DATA_W:0]     w_mul_sum, w_div_shift, w_div_diff;
  logic [2*DATA_W-1:0] w_prod;

  assign w_a_signed = (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
  assign w_b_signed = (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
  assign w_a_neg    = w_a_signed & operand_a[DATA_W-1];
  assign w_b_neg    = w_b_signed & operand_b[DATA_W-1];
  assign w_a_mag    = w_a_neg ? -operand_a : operand_a;
  assign w_b_mag    = w_b_neg ? -operand_b : operand_b;
  // Remainders take the dividend's sign; products and quotients the XOR.
  assign w_neg_res  = (op[2] & op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div0 = op[2] & (operand_b == '0);
  assign w_ovf  = op[2] & ~op[0] & (operand_a == L_MIN) & (operand_b == '1);
  assign w_fast = w_div0 | w_ovf;

  always_comb begin
    w_fast_res = '0;
    if (w_div0)
      w_fast_res = op[1] ? operand_a : '1;
    else if (w_ovf)
      w_fast_res = op[1] ? '0 : operand_a;
  end

  assign w_accept = start & ~flush & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

  // Multiplier bits sit in r_lo and shift out as the product shifts in.
  assign w_mul_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
  assign w_div_shift = {r_hi, r_lo[DATA_W-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};

  always_comb begin
    w_prod    = '0;
    w_field   = '0;
    w_fix_res = '0;
    if (!r_op[2]) begin
      w_prod    = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
      w_fix_res = (r_op[1:0] == 2'b00) ? w_prod[DATA_W-1:0] : w_prod[2*DATA_W-1:DATA_W];
    end else begin
      w_field   = r_op[1] ? r_hi : r_lo;
      w_fix_res = r_neg ? -w_field : w_field;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = w_fast ? S_DONE : S_CALC;
        S_CALC:  if (w_last) w_next = S_FIX;
        S_FIX:   w_next = S_DONE;
        S_DONE:  w_next = !start ? S_IDLE : (w_fast ? S_DONE : S_CALC);
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      r_state <= S_IDLE;
    else if (enable)
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else if (enable && !flush) begin
      if (w_accept) begin
        r_op  <= op;
        r_neg <= w_neg_res;
        r_cnt <= '0;
        r_hi  <= '0;
        if (w_fast) begin
          r_result <= w_fast_res;
        end else if (op[2]) begin
          r_lo <= w_a_mag;
          r_b  <= w_b_mag;
        end else begin
          r_lo <= w_b_mag;
          r_b  <= w_a_mag;
        end
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_op[2]) begin
          if (!w_div_diff[DATA_W]) begin
            r_hi <= w_div_diff[DATA_W-1:0];
            r_lo <= {r_lo[DATA_W-2:0], 1'b1};
          end else begin
            r_hi <= w_div_shift[DATA_W-1:0];
            r_lo <= {r_lo[DATA_W-2:0], 1'b0};
          end
        end else begin
          r_hi <= w_mul_sum[DATA_W:1];
          r_lo <= {w_mul_sum[0], r_lo[DATA_W-1:1]};
        end
      end else if (r_state == S_FIX) begin
        r_result <= w_fix_res;
      end
    end
  end

  assign busy   = (r_state == S_CALC) | (r_state == S_FIX);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule
